// File: rtl/chip8_pkg.sv
// chip8_pkg: shared CHIP-8 constants for the timer block and the CPU decoder.
package chip8_pkg;
    localparam int TIMER_W       = 8;
    localparam int CHIP8_TICK_HZ = 60;
    localparam logic [7:0] OP_LD_VX_DT = 8'h07;
    localparam logic [7:0] OP_LD_DT_VX = 8'h15;
    localparam logic [7:0] OP_LD_ST_VX = 8'h18;
endpackage

// File: rtl/chip8_tone_gen.sv
// chip8_tone_gen: TONE_HZ square wave, held in low phase with counter cleared while enable is low.
module chip8_tone_gen #(
    parameter int CLOCK_HZ = 12000000,
    parameter int TONE_HZ  = 440
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tone_out
);
    localparam int HALF = CLOCK_HZ / (2 * TONE_HZ);
    localparam int CW   = $clog2(HALF + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);
    logic [CW-1:0] cnt;
    logic          phase;
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    // gating with enable drops the output on the same cycle sound stops
    assign tone_out = phase & enable;
endmodule

// File: rtl/chip8_delay_sound_timers.sv
// chip8_delay_sound_timers: CHIP-8 DT/ST countdown registers and buzzer drive.
// CHIP8_BUZZER_TONE_EN selects a TONE_HZ square wave instead of a one-cycle-delayed sound_active level.
module chip8_delay_sound_timers
    import chip8_pkg::*;
#(
    parameter int CLOCK_HZ = 12000000,
    parameter int TONE_HZ  = 440
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_60hz,
    input  logic               halt,
    input  logic               dt_we,
    input  logic               st_we,
    input  logic [TIMER_W-1:0] wdata,
    output logic [TIMER_W-1:0] dt_value,
    output logic [TIMER_W-1:0] st_value,
    output logic               dt_expired,
    output logic               st_expired,
    output logic               sound_active,
    output logic               buzzer
);
    logic [TIMER_W-1:0] val [2];
    logic [1:0]         we;
    logic [1:0]         expired;
    assign we = {st_we, dt_we};
    for (genvar i = 0; i < 2; i++) begin : g_timer
        logic dec;
        assign dec = !we[i] && tick_60hz && !halt && val[i] != '0;
        always_ff @(posedge clk) begin
            if (rst) begin
                val[i]     <= '0;
                expired[i] <= 1'b0;
            end else begin
                val[i]     <= we[i] ? wdata : dec ? val[i] - 1'b1 : val[i];
                expired[i] <= dec && val[i] == TIMER_W'(1);
            end
        end
    end
    assign dt_value     = val[0];
    assign st_value     = val[1];
    assign dt_expired   = expired[0];
    assign st_expired   = expired[1];
    assign sound_active = st_value != '0;
`ifdef CHIP8_BUZZER_TONE_EN
    chip8_tone_gen #(.CLOCK_HZ(CLOCK_HZ), .TONE_HZ(TONE_HZ)) u_tone (
        .clk      (clk),
        .rst      (rst),
        .enable   (sound_active),
        .tone_out (buzzer)
    );
`else
    always_ff @(posedge clk) buzzer <= rst ? 1'b0 : sound_active;
`endif
endmodule

// File: doc/chip8_delay_sound_timers.md
Name: chip8_delay_sound_timers

Overview:
- Holds the CHIP-8 delay timer (DT) and sound timer (ST) registers.
- Consumes the 60 Hz tick from the system timer and decrements each non-zero register once per tick.
- Serves CPU accesses for LD DT,Vx (Fx15), LD ST,Vx (Fx18) and LD Vx,DT (Fx07).
- Drives the buzzer output while ST is non-zero. Sits between the tick generator and the CPU/audio pin.

Parameters:
- CLOCK_HZ, 12000000: system clock frequency in Hz. Used only by the tone generator.
- TONE_HZ, 440: buzzer square-wave frequency in Hz.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick_60hz  in  1  single-cycle pulse at 60 Hz from the system timer.
- halt  in  1  freezes both countdowns while high. Writes are still accepted.
- dt_we  in  1  load DT from wdata this cycle.
- st_we  in  1  load ST from wdata this cycle.
- wdata  in  8  value written by the CPU (Vx).
- dt_value  out  8  current DT, registered. Read directly by Fx07.
- st_value  out  8  current ST, registered.
- dt_expired  out  1  one-cycle pulse when DT goes 1->0 by decrement.
- st_expired  out  1  one-cycle pulse when ST goes 1->0 by decrement.
- sound_active  out  1  high iff st_value != 0.
- buzzer  out  1  audio output.

Behaviour:
- Reset: dt_value=0, st_value=0, dt_expired=0, st_expired=0, sound_active=0, buzzer=0. Tone counter and phase are cleared.
- rst has priority over all other inputs. Reset in the middle of a countdown or tone clears everything on that clock edge.
- Per register, evaluated each rising edge in priority order:
  1. we=1: load wdata. A load suppresses that cycle's decrement, even if tick_60hz=1.
  2. Else if tick_60hz=1, halt=0 and value!=0: decrement by 1.
  3. Else: hold.
- At 0, a tick leaves the register at 0. No wrap to 255.
- Expired pulse is asserted on the cycle after the register changes 1->0 by decrement, and lasts exactly one cycle.
- Loading 0 never produces an expired pulse. Loading over a running count produces no pulse.
- dt_we and st_we may be asserted together. Both registers load the same wdata.
- Latency:
  - Write on edge N: dt_value/st_value show the new value after edge N. CPU read-after-write in the next cycle sees the new value.
  - sound_active is a combinational decode of the st_value register, so it follows ST with zero added latency.
- halt=1 with tick_60hz=1: the tick is discarded, not deferred.
- Tone generator (see Optional Feature): when sound_active=0, buzzer=0, the half-period counter is 0 and the phase is 0. The tone therefore always starts in a defined phase.

Optional Feature:
- Macro: CHIP8_BUZZER_TONE_EN.
- Defined:
  - buzzer is a square wave at TONE_HZ while sound_active=1.
  - Half-period count HALF = CLOCK_HZ/(2*TONE_HZ), integer division.
  - The counter runs from 0 to HALF-1. The phase toggles on wrap, and buzzer = phase.
  - The first rising edge of buzzer occurs HALF cycles after sound_active rises. buzzer is low during the first half-period.
  - buzzer returns to 0 on the cycle sound_active falls.
  - Counter width is $clog2(HALF+1).
- Not defined:
  - buzzer = sound_active, registered with one cycle delay. Intended for an external active buzzer.
  - No counter logic is synthesised.

Decomposition:
- Shared package (chip8_pkg):
  - TIMER_W = 8.
  - CHIP8_TICK_HZ = 60.
  - Opcode low-byte constants OP_LD_VX_DT = 8'h07, OP_LD_DT_VX = 8'h15, OP_LD_ST_VX = 8'h18. The CPU decoder uses these to drive dt_we/st_we.
- One natural sub-module: chip8_tone_gen.
  - Ports: clk, rst, enable, tone_out; parameters CLOCK_HZ, TONE_HZ.
  - Instantiated only under CHIP8_BUZZER_TONE_EN.
- The two countdown registers share one internal function or generate loop. They are not separate modules.

Test Plan:
- Reset/load: assert rst 3 cycles, then dt_we with wdata=8'h03 -> dt_value=3 next cycle. 3 ticks -> 2,1,0, with dt_expired high exactly one cycle after the third tick. A 4th tick keeps 0 and gives no pulse.
- Write/tick collision: DT=5, dt_we=1 with wdata=8'h0A and tick_60hz=1 on the same edge -> dt_value=10, not 9. ST=0 with tick -> stays 0, no wrap to 8'hFF.
- Sound: st_we with wdata=8'h02 -> sound_active=1 immediately after load. After 2 ticks -> sound_active=0, st_expired single pulse. With the macro and CLOCK_HZ=1000, TONE_HZ=100 -> buzzer period is 10 clocks (5 low, 5 high), first high at cycle 5.
- Halt: DT=4, halt=1 across 3 ticks -> DT stays 4. Release halt, 1 tick -> 3. st_we during halt with wdata=8'h07 -> ST=7.
- Simultaneous writes: dt_we=st_we=1 with wdata=8'h2C -> both read 44. Load 0 into DT=1 -> no dt_expired.
- Reset mid-operation: ST=200 with buzzer toggling, assert rst for 1 cycle -> st_value=0, buzzer=0, sound_active=0 next cycle. No st_expired pulse.
